uart_frame_parser: RTL
======================

// Module: uart_frame_parser
// PURPOSE
//  Sits between the UART receiver and the LCD character-drawing controller.
//  Collects received bytes into fixed 5-byte frames: HEADER, X, Y, CHAR, SUM.
//  Checks each frame and hands valid draw requests (x, y, char) downstream on a
//  valid/ready handshake. Malformed, stale or out-of-range frames are dropped
//  and counted.
// PARAMETERS
//  HEADER       8'hA5   frame start byte
//  TIMEOUT_CYC  'd50000 max clk cycles between bytes of one frame (>=2)
//  X_MAX        8'd159  largest legal X; X > X_MAX rejects the frame
//  Y_MAX        8'd79   largest legal Y; Y > Y_MAX rejects the frame
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  rx_data    in   8  received byte, valid while rx_valid=1
//  rx_valid   in   1  one-cycle strobe per received byte
//  out_valid  out  1  draw request pending
//  out_ready  in   1  downstream accepts the request when out_valid&out_ready
//  out_x      out  8  column of pending request
//  out_y      out  8  row of pending request
//  out_char   out  8  character code of pending request
//  busy       out  1  1 while the FSM is not in IDLE
//  err_cnt    out  8  dropped-frame count, saturates at 8'hFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, timeout counter=0, buffer empty.
//  - FSM: IDLE -> GET_X -> GET_Y -> GET_CH -> GET_SUM -> IDLE.
//    Each transition happens only on rx_valid.
//  - IDLE: a byte equal to HEADER goes to GET_X. Any other byte is ignored
//    and is not counted.
//  - GET_X/GET_Y/GET_CH: the byte is latched into a shadow register.
//  - GET_SUM: the frame is good if both hold:
//      SUM == X^Y^CHAR
//      X <= X_MAX and Y <= Y_MAX
//    The FSM returns to IDLE whether the frame is good or bad.
//  - Good frame, buffer empty, or draining this cycle (out_valid&out_ready):
//    out_x/out_y/out_char are loaded and out_valid=1 on the next cycle.
//    Latency is 1 clk after the SUM byte's rx_valid.
//  - Good frame with buffer full and not draining: frame dropped, err_cnt+1.
//    The pending request is left untouched.
//  - Bad SUM or range: frame dropped, err_cnt+1.
//  - Output buffer is one entry deep. out_x/out_y/out_char stay stable while
//    out_valid=1. out_valid clears the cycle after out_valid&out_ready unless
//    a reload happens in the same cycle.
//  - Timeout: in any non-IDLE state the counter increments every clk and
//    clears on rx_valid. Reaching TIMEOUT_CYC-1 without a byte forces IDLE
//    and err_cnt+1.
//  - A HEADER byte arriving mid-frame is treated as data, not a resync.
//  - err_cnt saturates at 8'hFF and never wraps.
//  - rst mid-frame or with a request pending: everything returns to reset
//    values; the pending request is lost.
// CONFIGURATION
//  PARSER_ECHO_EN defined:
//    Adds ports tx_data(out,8), tx_start(out,1), tx_busy(in,1).
//    After each frame is resolved, one status byte is queued for the UART
//    transmitter: 8'h06 = accepted, 8'h15 = dropped (SUM, range, overflow
//    or timeout).
//    tx_start pulses 1 clk when the byte is pending and tx_busy=0.
//    Holding register is one deep; a newer status overwrites an unsent one.
//  PARSER_ECHO_EN undefined:
//    None of these ports or that logic exist; the block is silent.
// TESTING
//  1. Send A5 10 20 41 71 with out_ready=1 -> one out_valid pulse,
//     x=8'h10, y=8'h20, char=8'h41; err_cnt=0.
//  2. Send A5 10 20 41 00 (bad SUM) -> no out_valid; err_cnt=1; busy=0.
//  3. Send A5 C8 00 41 89 (X>X_MAX) -> dropped; err_cnt=1.
//  4. out_ready=0, send two good frames -> first held stable; second dropped,
//     err_cnt=1. Raise out_ready -> first consumed, out_valid falls.
//  5. Send A5 10, then idle for TIMEOUT_CYC clk -> busy falls; err_cnt=1.
//     Next full good frame is accepted.
//  6. PARSER_ECHO_EN, tx_busy=0: good frame -> tx_start with 8'h06.
//     Bad frame -> tx_start with 8'h15. Also assert rst mid-frame -> all
//     outputs back to 0.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte draw frames (HEADER, X, Y, CHAR, SUM) from the UART receiver and
// offers checked requests on a one-deep valid/ready buffer. Optional status echo: PARSER_ECHO_EN.
module uart_frame_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  X_MAX       = 8'd159,
  parameter logic [7:0]  Y_MAX       = 8'd79
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [7:0] out_char,
  output logic       busy,
  output logic [7:0] err_cnt
`ifdef PARSER_ECHO_EN
  ,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
`endif
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StGetX, StGetY, StGetCh, StGetSum} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      x_q, x_d, y_q, y_d, ch_q, ch_d;
  logic            ov_q, ov_d;
  logic [7:0]      ox_q, ox_d, oy_q, oy_d, och_q, och_d;
  logic [7:0]      err_q, err_d;
  logic            drain, timeout, resolve, frame_ok, load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    ch_d     = ch_q;
    ov_d     = ov_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    och_d    = och_q;
    err_d    = err_q;
    resolve  = 1'b0;
    frame_ok = 1'b0;

    drain   = ov_q & out_ready;
    timeout = (state_q != StIdle) && !rx_valid && (cnt_q == CntLast);

    if (state_q == StIdle || rx_valid || timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle:   if (rx_valid && rx_data == HEADER) state_d = StGetX;
      StGetX:   if (rx_valid) begin x_d = rx_data; state_d = StGetY; end
      StGetY:   if (rx_valid) begin y_d = rx_data; state_d = StGetCh; end
      StGetCh:  if (rx_valid) begin ch_d = rx_data; state_d = StGetSum; end
      StGetSum: begin
        if (rx_valid) begin
          state_d  = StIdle;
          resolve  = 1'b1;
          frame_ok = (rx_data == (x_q ^ y_q ^ ch_q)) && (x_q <= X_MAX) && (y_q <= Y_MAX);
        end
      end
      default:  state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      resolve = 1'b1;
    end

    // A slot frees up in the same cycle it drains, so back-to-back requests never stall.
    load = resolve && frame_ok && (!ov_q || drain);
    if (load) begin
      ov_d  = 1'b1;
      ox_d  = x_q;
      oy_d  = y_q;
      och_d = ch_q;
    end else if (drain) begin
      ov_d = 1'b0;
    end

    if (resolve && !load && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ch_q    <= '0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      och_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      och_q   <= och_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_char  = och_q;
  assign busy      = (state_q != StIdle);
  assign err_cnt   = err_q;

`ifdef PARSER_ECHO_EN
  logic       tx_pend_q, tx_pend_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    tx_pend_d = tx_pend_q;
    tx_data_d = tx_data_q;
    // A fresh status replaces any byte the transmitter has not taken yet.
    if (resolve) begin
      tx_pend_d = 1'b1;
      tx_data_d = load ? 8'h06 : 8'h15;
    end else if (tx_start) begin
      tx_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pend_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_pend_q <= tx_pend_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start = tx_pend_q & ~tx_busy;
  assign tx_data  = tx_data_q;
`endif

endmodule
